// File: rtl/mm_auto_codebreaker_pkg.sv
// rtl/mm_auto_codebreaker_pkg.sv - shared types and helpers for the Mastermind codebreaker
package mm_pkg;

    localparam int NUM_SHAPES = 6;
    localparam int NUM_POS    = 4;

    typedef logic [2:0] shape_t;
    typedef shape_t [NUM_POS-1:0] code_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ISSUE,
        S_WAIT_FB,
        S_SEARCH,
        S_DONE
    } state_t;

    typedef struct packed {
        code_t      guess;
        logic [2:0] exact;
        logic [2:0] partial;
    } hist_entry_t;

    // Base-6 odometer step; bit 12 is the carry out of digit 3.
    function automatic logic [12:0] code_inc(input code_t c);
        code_t r;
        logic  carry;
        r     = c;
        carry = 1'b1;
        for (int p = 0; p < NUM_POS; p++) begin
            if (carry) begin
                if (r[p] == shape_t'(NUM_SHAPES - 1)) begin
                    r[p] = 3'd0;
                end else begin
                    r[p]  = r[p] + 3'd1;
                    carry = 1'b0;
                end
            end
        end
        return {carry, r};
    endfunction

endpackage

// File: rtl/mm_auto_codebreaker_if.sv
// rtl/mm_auto_codebreaker_if.sv - guess/feedback bundle between codebreaker and grader
interface mm_auto_codebreaker_if;
    import mm_pkg::*;

    logic       go;
    logic       fb_valid;
    logic [2:0] exact;
    logic [2:0] partial;
    logic       won;
    logic       lost;
    logic       start_game;
    logic       grade_it;
    code_t      guess;
    logic [3:0] round_number;
    logic       busy;
    logic       done;
    logic       solved;
    logic       error;

    modport master (
        input  go, fb_valid, exact, partial, won, lost,
        output start_game, grade_it, guess, round_number, busy, done, solved, error
    );

    modport slave (
        output go, fb_valid, exact, partial, won, lost,
        input  start_game, grade_it, guess, round_number, busy, done, solved, error
    );
endinterface

// File: rtl/mm_auto_codebreaker_score.sv
// rtl/mm_auto_codebreaker_score.sv - combinational Mastermind scorer (exact/partial)
module mm_score
    import mm_pkg::*;
(
    input  code_t      a,
    input  code_t      b,
    output logic [2:0] exact,
    output logic [2:0] partial
);

    logic [2:0] common;
    logic [2:0] cnt_a;
    logic [2:0] cnt_b;

    always_comb begin
        exact  = 3'd0;
        common = 3'd0;
        cnt_a  = 3'd0;
        cnt_b  = 3'd0;
        for (int p = 0; p < NUM_POS; p++) begin
            if (a[p] == b[p]) exact = exact + 3'd1;
        end
        for (int s = 0; s < NUM_SHAPES; s++) begin
            cnt_a = 3'd0;
            cnt_b = 3'd0;
            for (int p = 0; p < NUM_POS; p++) begin
                if (a[p] == shape_t'(s)) cnt_a = cnt_a + 3'd1;
                if (b[p] == shape_t'(s)) cnt_b = cnt_b + 3'd1;
            end
            common = common + ((cnt_a < cnt_b) ? cnt_a : cnt_b);
        end
        partial = common - exact;
    end

endmodule

// File: rtl/mm_auto_codebreaker.sv
// rtl/mm_auto_codebreaker.sv - automatic codebreaker: issues guesses consistent with all prior feedback
module mm_auto_codebreaker
    import mm_pkg::*;
#(
    parameter int          MAX_ROUNDS  = 8,
    parameter logic [11:0] FIRST_GUESS = 12'h009
) (
    input  logic                  clock,
    input  logic                  reset,
    mm_auto_codebreaker_if.master bus
);

    localparam int IW = (MAX_ROUNDS > 1) ? $clog2(MAX_ROUNDS) : 1;

    state_t      state;
    code_t       guess_q;
    code_t       cand;
    logic [3:0]  round_q;
    logic [3:0]  idx;
    logic        start_q;
    logic        grade_q;
    logic        solved_q;
    logic        error_q;
    hist_entry_t history [MAX_ROUNDS];

    hist_entry_t rd_entry;
    logic [2:0]  s_exact;
    logic [2:0]  s_partial;
    logic [12:0] guess_inc;
    logic [12:0] cand_inc;
    logic [3:0]  round_nx;
    logic        fb_take;

    assign rd_entry  = history[idx[IW-1:0]];
    assign guess_inc = code_inc(guess_q);
    assign cand_inc  = code_inc(cand);
    assign round_nx  = round_q + 4'd1;
    assign fb_take   = (state == S_WAIT_FB) && bus.fb_valid;

    mm_score u_score (
        .a      (cand),
        .b      (rd_entry.guess),
        .exact  (s_exact),
        .partial(s_partial)
    );

    // History carries no reset: it is only read below round_number, which reset clears.
    always_ff @(posedge clock) begin
        if (!reset && fb_take) begin
            history[round_q[IW-1:0]] <= '{guess: guess_q, exact: bus.exact, partial: bus.partial};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            guess_q  <= '0;
            cand     <= '0;
            round_q  <= 4'd0;
            idx      <= 4'd0;
            start_q  <= 1'b0;
            grade_q  <= 1'b0;
            solved_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            grade_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.go) begin
                        state    <= S_START;
                        start_q  <= 1'b1;
                        round_q  <= 4'd0;
                        solved_q <= 1'b0;
                        error_q  <= 1'b0;
                        guess_q  <= code_t'(FIRST_GUESS);
                    end
                end
                S_START: begin
                    state   <= S_ISSUE;
                    grade_q <= 1'b1;
                end
                S_ISSUE: begin
                    state <= S_WAIT_FB;
                end
                S_WAIT_FB: begin
                    if (bus.fb_valid) begin
                        round_q <= round_nx;
                        if (bus.exact == 3'd4 || bus.won) begin
                            state    <= S_DONE;
                            solved_q <= 1'b1;
                        end else if (bus.lost || round_nx == 4'(MAX_ROUNDS)) begin
                            state <= S_DONE;
                        end else if (guess_inc[12]) begin
                            // Last guess was 5555: nothing above it remains to try.
                            state   <= S_DONE;
                            error_q <= 1'b1;
                        end else begin
                            state <= S_SEARCH;
                            cand  <= guess_inc[11:0];
                            idx   <= 4'd0;
                        end
                    end
                end
                S_SEARCH: begin
                    if (s_exact != rd_entry.exact || s_partial != rd_entry.partial) begin
                        if (cand_inc[12]) begin
                            state   <= S_DONE;
                            error_q <= 1'b1;
                        end else begin
                            cand <= cand_inc[11:0];
                            idx  <= 4'd0;
                        end
                    end else if (idx != round_q - 4'd1) begin
                        idx <= idx + 4'd1;
                    end else begin
                        guess_q <= cand;
                        state   <= S_ISSUE;
                        grade_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.start_game   = start_q;
    assign bus.grade_it     = grade_q;
    assign bus.guess        = guess_q;
    assign bus.round_number = round_q;
    assign bus.busy         = (state != S_IDLE) && (state != S_DONE);
    assign bus.done         = (state == S_DONE);
    assign bus.solved       = solved_q;
    assign bus.error        = error_q;

endmodule

// File: tb/tb_mm_auto_codebreaker.sv
// tb/tb_mm_auto_codebreaker.sv - directed bench with a grader model and guess scoreboard
module tb_mm_auto_codebreaker;
    import mm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mm_auto_codebreaker_if bus ();

    mm_auto_codebreaker #(.MAX_ROUNDS(8), .FIRST_GUESS(12'h009)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    int          ntests = 0;
    int          nfail  = 0;
    logic [11:0] exp_q[$];
    logic [11:0] hg[16];
    logic [2:0]  he[16];
    logic [2:0]  hp[16];
    int          hn;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Marking-based reference scorer.
    function automatic void ref_score(input logic [11:0] a, input logic [11:0] b,
                                      output logic [2:0] e, output logic [2:0] p);
        bit ua[4];
        bit ub[4];
        bit hit;
        e = 3'd0;
        p = 3'd0;
        for (int i = 0; i < 4; i++) begin
            ua[i] = (a[3*i +: 3] == b[3*i +: 3]);
            ub[i] = ua[i];
            if (ua[i]) e = e + 3'd1;
        end
        for (int i = 0; i < 4; i++) begin
            hit = 1'b0;
            if (!ua[i]) begin
                for (int j = 0; j < 4; j++) begin
                    if (!hit && !ub[j] && a[3*i +: 3] == b[3*j +: 3]) begin
                        ub[j] = 1'b1;
                        hit   = 1'b1;
                        p     = p + 3'd1;
                    end
                end
            end
        end
    endfunction

    task automatic send_fb(input logic [2:0] e, input logic [2:0] p, input bit lst);
        tick;
        bus.fb_valid = 1'b1;
        bus.exact    = e;
        bus.partial  = p;
        bus.won      = (e == 3'd4);
        bus.lost     = lst;
        tick;
        bus.fb_valid = 1'b0;
        bus.won      = 1'b0;
        bus.lost     = 1'b0;
    endtask

    task automatic start_seq(input string tag);
        bus.go = 1'b1;
        tick;
        bus.go = 1'b0;
        check({tag, "_start_pulse"}, 16'(bus.start_game), 16'd1);
        check({tag, "_no_grade_yet"}, 16'(bus.grade_it), 16'd0);
        tick;
        check({tag, "_start_cleared"}, 16'(bus.start_game), 16'd0);
        check({tag, "_grade_pulse"}, 16'(bus.grade_it), 16'd1);
        check({tag, "_first_guess"}, 16'(bus.guess), 16'h009);
    endtask

    // Entered with grade_it high; plays until done.
    task automatic grade_loop(input logic [11:0] secret, input bit zero_fb, input int lost_at);
        logic [2:0] e, p, ge, gp;
        bit ok;
        int cyc;
        hn = 0;
        for (int r = 0; r < 20; r++) begin
            ok = 1'b1;
            for (int k = 0; k < hn; k++) begin
                ref_score(bus.guess, hg[k], ge, gp);
                if (ge != he[k] || gp != hp[k]) ok = 1'b0;
            end
            check("guess_consistent", 16'(ok), 16'd1);
            if (exp_q.size() > 0) check("guess_seq", 16'(bus.guess), 16'(exp_q.pop_front()));
            if (zero_fb) begin
                e = 3'd0;
                p = 3'd0;
            end else begin
                ref_score(bus.guess, secret, e, p);
            end
            hg[hn] = bus.guess;
            he[hn] = e;
            hp[hn] = p;
            hn++;
            send_fb(e, p, (hn == lost_at));
            cyc = 0;
            while (!bus.grade_it && !bus.done && cyc < 20000) begin
                tick;
                cyc++;
            end
            check("grade_or_done_in_time", 16'(cyc < 20000), 16'd1);
            if (bus.done || cyc >= 20000) break;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int cyc;
        bus.go       = 1'b0;
        bus.fb_valid = 1'b0;
        bus.exact    = 3'd0;
        bus.partial  = 3'd0;
        bus.won      = 1'b0;
        bus.lost     = 1'b0;

        // Reset state
        repeat (3) tick;
        rst = 1'b0;
        repeat (5) tick;
        check("rst_start_game", 16'(bus.start_game), 16'd0);
        check("rst_grade_it", 16'(bus.grade_it), 16'd0);
        check("rst_guess", 16'(bus.guess), 16'h000);
        check("rst_round", 16'(bus.round_number), 16'd0);
        check("rst_busy", 16'(bus.busy), 16'd0);
        check("rst_done", 16'(bus.done), 16'd0);
        check("rst_solved", 16'(bus.solved), 16'd0);
        check("rst_error", 16'(bus.error), 16'd0);

        // Stray fb_valid in IDLE
        send_fb(3'd4, 3'd0, 1'b0);
        check("idle_fb_busy", 16'(bus.busy), 16'd0);
        check("idle_fb_done", 16'(bus.done), 16'd0);
        check("idle_fb_round", 16'(bus.round_number), 16'd0);

        // Secret equals opening guess
        start_seq("g1");
        grade_loop(12'h009, 1'b0, 0);
        check("g1_done", 16'(bus.done), 16'd1);
        check("g1_solved", 16'(bus.solved), 16'd1);
        check("g1_error", 16'(bus.error), 16'd0);
        check("g1_round", 16'(bus.round_number), 16'd1);

        // All-zero feedback exhausts the candidate space
        exp_q.push_back(12'h009);
        exp_q.push_back(12'h492);
        exp_q.push_back(12'h6DB);
        exp_q.push_back(12'h924);
        exp_q.push_back(12'hB6D);
        start_seq("g2");
        grade_loop(12'h000, 1'b1, 0);
        check("g2_done", 16'(bus.done), 16'd1);
        check("g2_error", 16'(bus.error), 16'd1);
        check("g2_solved", 16'(bus.solved), 16'd0);
        check("g2_round", 16'(bus.round_number), 16'd5);
        check("g2_queue_empty", 16'(exp_q.size()), 16'd0);

        // Real grader, secret {3,5,0,2}
        start_seq("g3");
        check("g3_error_cleared", 16'(bus.error), 16'd0);
        grade_loop(12'h742, 1'b0, 0);
        check("g3_done", 16'(bus.done), 16'd1);
        check("g3_solved", 16'(bus.solved), 16'd1);
        check("g3_error", 16'(bus.error), 16'd0);
        check("g3_round_le_max", 16'(bus.round_number <= 4'd8), 16'd1);
        check("g3_last_guess", 16'(bus.guess), 16'h742);

        // Loss on third feedback
        exp_q.push_back(12'h009);
        exp_q.push_back(12'h492);
        exp_q.push_back(12'h6DB);
        start_seq("g4");
        grade_loop(12'h000, 1'b1, 3);
        check("g4_done", 16'(bus.done), 16'd1);
        check("g4_solved", 16'(bus.solved), 16'd0);
        check("g4_error", 16'(bus.error), 16'd0);
        check("g4_round", 16'(bus.round_number), 16'd3);
        seen = 0;
        repeat (5) begin
            tick;
            if (bus.grade_it) seen++;
        end
        check("g4_no_more_grade", 16'(seen), 16'd0);
        check("g4_done_holds", 16'(bus.done), 16'd1);

        // Stray fb_valid and go during SEARCH, then reset mid-SEARCH
        start_seq("g5");
        send_fb(3'd0, 3'd0, 1'b0);
        repeat (3) tick;
        check("g5_searching", 16'(bus.busy), 16'd1);
        bus.fb_valid = 1'b1;
        bus.go       = 1'b1;
        tick;
        bus.fb_valid = 1'b0;
        bus.go       = 1'b0;
        check("g5_stray_round", 16'(bus.round_number), 16'd1);
        check("g5_stray_no_start", 16'(bus.start_game), 16'd0);
        check("g5_stray_busy", 16'(bus.busy), 16'd1);
        cyc = 0;
        while (!bus.grade_it && cyc < 20000) begin
            tick;
            cyc++;
        end
        check("g5_grade_in_time", 16'(cyc < 20000), 16'd1);
        check("g5_second_guess", 16'(bus.guess), 16'h492);
        send_fb(3'd0, 3'd0, 1'b0);
        repeat (2) tick;
        check("g5_search_again", 16'(bus.busy), 16'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("g5_rst_busy", 16'(bus.busy), 16'd0);
        check("g5_rst_done", 16'(bus.done), 16'd0);
        check("g5_rst_round", 16'(bus.round_number), 16'd0);
        check("g5_rst_guess", 16'(bus.guess), 16'h000);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/mm_auto_codebreaker.md
# mm_auto_codebreaker

Automatic Mastermind codebreaker that plays against the grader from the opposite side of the guess/feedback interface. It pulses start_game, issues 12-bit guesses with a one-cycle grade_it strobe, and consumes the grader's exact/partial feedback. From that history it searches for the next guess consistent with every previous result. It sits beside the game core in place of the switch/button player and drives the same guess and grade_it nets.

## Interface
Parameters:
- MAX_ROUNDS, 8: history depth and the round limit; legal range 1..15.
- FIRST_GUESS, 12'h009: opening guess, shapes {0,0,1,1}.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- go  in  1  one-cycle request to begin a game; honoured only in IDLE or DONE.
- fb_valid  in  1  one-cycle strobe marking exact/partial/won/lost as valid for the last graded guess.
- exact  in  3  count of correct shape in correct position, 0..4.
- partial  in  3  count of correct shape in wrong position, 0..4.
- won  in  1  grader win flag, sampled with fb_valid.
- lost  in  1  grader loss flag, sampled with fb_valid.
- start_game  out  1  one-cycle pulse to the grader.
- grade_it  out  1  one-cycle pulse; guess is valid in the same cycle.
- guess  out  12  current guess; [11:9] is position 3 and [2:0] is position 0; each field is a shape 0..5.
- round_number  out  4  count of guesses graded so far.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- solved  out  1  valid while done; 1 means exact==4 or won.
- error  out  1  valid while done; 1 means the candidate space is exhausted, i.e. the feedback is inconsistent.

## Operation
- States: IDLE, START, ISSUE, WAIT_FB, SEARCH, DONE.
- IDLE/DONE → START on go. On entry to START, clear round_number, solved, error, history count, and guess ← FIRST_GUESS.
- START: start_game=1 for one cycle → ISSUE.
- ISSUE: grade_it=1 for one cycle → WAIT_FB.
- WAIT_FB: hold until fb_valid. On fb_valid:
  - write history[round_number] ← {guess, exact, partial};
  - round_number++;
  - then branch, in this priority:
    - exact==4 or won → DONE, solved=1;
    - lost, or round_number reaches MAX_ROUNDS → DONE, solved=0;
    - otherwise → SEARCH with candidate ← guess+1 and index i ← 0.
- Candidate increment is a base-6 odometer: digit 0 is least significant, 5 rolls to 0 with carry into the next digit.
- SEARCH compares one history entry per cycle. The scorer compares candidate with history[i].guess.
  - Result mismatches the stored exact/partial: candidate++, i ← 0.
  - Match and i < round_number−1: i++.
  - Match on the last entry: guess ← candidate → ISSUE.
  - Candidate increment carries out of digit 3 (past 5555): → DONE, error=1, solved=0.
- Candidates below the current one are never revisited. Inconsistency with a fixed history is permanent, so the search never restarts from 0.
- fb_valid outside WAIT_FB is ignored. go outside IDLE/DONE is ignored.
- guess changes only on entry to START or on the SEARCH→ISSUE transition; otherwise it holds.

## Timing
- Reset values: state IDLE, guess 12'h000, round_number 0, and all 1-bit outputs 0. Reset takes effect on any state, including mid-SEARCH; history contents are don't-care after reset.
- Latency:
  - go → start_game: 1 cycle.
  - start_game → grade_it: 1 cycle.
  - fb_valid → next grade_it: 2 + (number of SEARCH cycles) cycles.
- Worst-case SEARCH length is at most 1296·MAX_ROUNDS cycles.
- DONE outputs (done, solved, error) hold until the next go or reset.
- Scoring is combinational within one cycle:
  - exact = number of positions with equal shape;
  - partial = Σ over shapes s of min(countA(s), countB(s)) − exact;
  - all arithmetic is 3 bits wide and cannot overflow (maximum 4).

## Structure
- Package mm_pkg:
  - shape_t (3 bits), code_t (4×shape_t packed, 12 bits);
  - NUM_SHAPES=6, NUM_POS=4;
  - state enum;
  - hist_entry_t {code_t guess; logic [2:0] exact, partial}.
- Sub-module mm_score: purely combinational (code_t a, b → exact, partial), instantiated once in SEARCH.
- History is a register array of MAX_ROUNDS entries, indexed by round_number for writes and by i for reads.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, guess 12'h000. Assert reset mid-SEARCH → IDLE next cycle, busy=0.
- go with a grader model holding secret 12'h009 → start_game 1 cycle after go, grade_it the cycle after that with guess 12'h009. fb_valid with exact=4 → done=1, solved=1, round_number=1.
- Grader always returns exact=0, partial=0 → guesses 12'h009, 12'h492 (2222), 12'h6DB (3333), 12'h924 (4444), 12'hB6D (5555); after the fifth feedback → done=1, error=1, round_number=5.
- Secret {3,5,0,2} with a correct grader model → solved=1 with round_number ≤ MAX_ROUNDS. Every issued guess must be consistent with all prior feedback when checked against a reference mm_score.
- Grader asserts lost with the 3rd fb_valid → done=1, solved=0, round_number=3, no further grade_it.
- Stray fb_valid in IDLE and during SEARCH, plus go while busy → ignored: no state change, round_number unchanged.
